// File: rtl/ifu_cache_ctrl_if.sv
// Signal bundle between the IFU cache controller, the fetch front end,
// the refill memory port, the data array and the PLRU block.
interface ifu_cache_ctrl_if #(
    parameter int WAYS_NUM = 16,
    parameter int ADDR_W   = 32
);
    localparam int WAY_W = $clog2(WAYS_NUM);

    typedef struct packed {
        logic update_counter;
        logic update_tree;
    } t_cache_ctrl2_plru;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              flush;
    logic              rsp_valid;
    logic [WAY_W-1:0]  rsp_way;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic              fill_we;
    logic [WAY_W-1:0]  fill_way;
    t_cache_ctrl2_plru cache_ctrl2_plru;
    logic              cache_miss;
    logic [WAY_W-1:0]  hit_cl;
    logic [WAY_W-1:0]  evicted_cl;

    modport slave (
        input  req_valid, req_addr, flush, mem_req_ready, mem_rsp_valid, evicted_cl,
        output req_ready, rsp_valid, rsp_way, mem_req_valid, mem_req_addr,
               fill_we, fill_way, cache_ctrl2_plru, cache_miss, hit_cl
    );

    modport master (
        output req_valid, req_addr, flush, mem_req_ready, mem_rsp_valid, evicted_cl,
        input  req_ready, rsp_valid, rsp_way, mem_req_valid, mem_req_addr,
               fill_we, fill_way, cache_ctrl2_plru, cache_miss, hit_cl
    );
endinterface

// File: rtl/ifu_cache_ctrl.sv
// Tag/valid array and lookup/refill sequencer for a fully-associative
// I-cache; victim selection is delegated to the downstream PLRU block.
module ifu_cache_ctrl #(
    parameter int WAYS_NUM = 16,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 4,
    parameter int TAG_W    = ADDR_W - OFFSET_W
) (
    input logic            clk,
    input logic            rst,
    ifu_cache_ctrl_if.slave bus
);
    localparam int WAY_W = $clog2(WAYS_NUM);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        RESP
    } state_t;

    state_t              state;
    logic [WAYS_NUM-1:0] valid;
    logic [TAG_W-1:0]    tags [WAYS_NUM];
    logic [ADDR_W-1:0]   addr_q;
    logic [WAY_W-1:0]    victim;
    logic [TAG_W-1:0]    tag_q;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;

    assign tag_q = addr_q[ADDR_W-1:OFFSET_W];

    // Parallel tag compare; the first match in ascending order wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned i = 0; i < WAYS_NUM; i++) begin
            if (!hit && valid[i] && (tags[i] == tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            valid  <= '0;
            victim <= '0;
            addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        valid <= '0;
                    end else if (bus.req_valid) begin
                        addr_q <= bus.req_addr;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        state <= IDLE;
                    end else begin
                        victim <= bus.evicted_cl;
                        state  <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (bus.mem_req_ready) state <= MISS_WAIT;
                end
                MISS_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        tags[victim]  <= tag_q;
                        valid[victim] <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state and the live compare so a hit answers in the
    // LOOKUP cycle; everything is held at zero while reset is asserted.
    always_comb begin
        bus.req_ready        = 1'b0;
        bus.rsp_valid        = 1'b0;
        bus.rsp_way          = '0;
        bus.mem_req_valid    = 1'b0;
        bus.mem_req_addr     = '0;
        bus.fill_we          = 1'b0;
        bus.fill_way         = '0;
        bus.cache_ctrl2_plru = '0;
        bus.cache_miss       = 1'b0;
        bus.hit_cl           = '0;
        if (rst) begin
            case (state)
                IDLE: bus.req_ready = 1'b1;
                LOOKUP: begin
                    bus.cache_ctrl2_plru = '1;
                    bus.cache_miss       = !hit;
                    bus.hit_cl           = hit_way;
                    bus.rsp_valid        = hit;
                    bus.rsp_way          = hit_way;
                end
                MISS_REQ: begin
                    bus.mem_req_valid = 1'b1;
                    bus.mem_req_addr  = {tag_q, {OFFSET_W{1'b0}}};
                end
                MISS_WAIT: begin
                    bus.fill_we  = bus.mem_rsp_valid;
                    bus.fill_way = bus.mem_rsp_valid ? victim : '0;
                end
                RESP: begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_way   = victim;
                end
                default: ;
            endcase
        end
    end
endmodule
